// File: rtl/snake_pkg.sv
// Shared grid geometry, direction encoding and cell types for the snake game blocks
// (body engine, VGA renderer, cherry generator).
package snake_pkg;

  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int XW      = 6;
  localparam int YW      = 5;
  localparam int MAX_LEN = 32;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } cell_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } btn_t;

  // The encoding pairs opposites on bit 0, so a flip of bit 0 reverses a direction.
  function automatic dir_t dir_opposite(input dir_t d);
    return d ^ 2'd1;
  endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Direction request latch: button priority, reversal filter, pending and current dir.
// The direction used by a step is the pending one; it becomes current on that step.
module snake_dir_latch
  import snake_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic step,
  input  btn_t btn,
  output dir_t step_dir
);

  dir_t dir_q, dir_d;
  dir_t pend_q, pend_d;
  dir_t req;
  logic req_vld;

  always_comb begin
    req_vld = 1'b1;
    req     = DIR_RIGHT;
    if (btn.up)         req = DIR_UP;
    else if (btn.down)  req = DIR_DOWN;
    else if (btn.left)  req = DIR_LEFT;
    else if (btn.right) req = DIR_RIGHT;
    else                req_vld = 1'b0;

    // Filter against the direction of the last step so the head never folds onto the neck.
    pend_d = pend_q;
    if (req_vld && (req != dir_opposite(dir_q)))
      pend_d = req;

    dir_d = step ? pend_q : dir_q;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      dir_q  <= DIR_RIGHT;
      pend_q <= DIR_RIGHT;
    end else begin
      dir_q  <= dir_d;
      pend_q <= pend_d;
    end
  end

  assign step_dir = pend_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement/collision engine: body shift register, wall/self collision,
// cherry eat pulse and registered cell queries for the VGA renderer.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int EAT_HOLD = 4,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gamePrepare,
  input  logic          gameStart,
  input  logic [4:0]    size,
  input  logic          btnUp,
  input  logic          btnDown,
  input  logic          btnLeft,
  input  logic          btnRight,
  input  logic [XW-1:0] cherryX,
  input  logic [YW-1:0] cherryY,
  input  logic [XW-1:0] queryX,
  input  logic [YW-1:0] queryY,
  output logic          snakeEatCherry,
  output logic          bump,
  output logic [XW-1:0] headX,
  output logic [YW-1:0] headY,
  output logic          isBody,
  output logic          isHead
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(EAT_HOLD + 1);
  localparam cell_t START_C = '{x: XW'(START_X), y: YW'(START_Y)};

  cell_t [MAX_LEN-1:0] seg_q, seg_d;
  logic  [TW-1:0]      tick_q, tick_d;
  logic  [HW-1:0]      hold_q, hold_d;
  logic                bump_q, bump_d;
  logic                is_body_q, is_body_d;
  logic                is_head_q, is_head_d;

  logic  clr, run, step, wall, collide;
  logic  [5:0] len;
  dir_t  step_dir;
  btn_t  btn;
  cell_t nxt, cherry, qry;
  logic  [MAX_LEN-1:0] self_hit, q_hit;

  assign clr    = gamePrepare;
  assign btn    = {btnUp, btnDown, btnLeft, btnRight};
  assign cherry = {cherryX, cherryY};
  assign qry    = {queryX, queryY};
  // A 5-bit size already tops out at 31; only zero needs lifting.
  assign len    = (size == 5'd0) ? 6'd1 : {1'b0, size};

  assign run  = gameStart && !bump_q;
  assign step = run && (tick_q == TW'(TICK_DIV - 1));

  snake_dir_latch u_dir (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .step     (step),
    .btn      (btn),
    .step_dir (step_dir)
  );

  always_comb begin
    nxt  = seg_q[0];
    wall = 1'b0;
    case (step_dir)
      DIR_UP: begin
        wall  = (seg_q[0].y == '0);
        nxt.y = seg_q[0].y - YW'(1);
      end
      DIR_DOWN: begin
        wall  = (seg_q[0].y == YW'(GRID_H - 1));
        nxt.y = seg_q[0].y + YW'(1);
      end
      DIR_LEFT: begin
        wall  = (seg_q[0].x == '0);
        nxt.x = seg_q[0].x - XW'(1);
      end
      default: begin
        wall  = (seg_q[0].x == XW'(GRID_W - 1));
        nxt.x = seg_q[0].x + XW'(1);
      end
    endcase
  end

  // Segment 0 is the head itself and the tail seg[len-1] vacates on the step,
  // so only 1..len-2 can be struck.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    if (i == 0) begin : g_head
      assign self_hit[i] = 1'b0;
    end else begin : g_body
      assign self_hit[i] = (seg_q[i] == nxt) && (6'(i + 2) <= len);
    end
    assign q_hit[i] = (seg_q[i] == qry) && (6'(i) < len);
  end

  assign collide = wall || (|self_hit);

  always_comb begin
    tick_d    = tick_q;
    seg_d     = seg_q;
    bump_d    = bump_q;
    hold_d    = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
    is_body_d = |q_hit;
    is_head_d = q_hit[0];

    if (run)
      tick_d = (tick_q == TW'(TICK_DIV - 1)) ? '0 : tick_q + TW'(1);

    if (step) begin
      if (collide) begin
        bump_d = 1'b1;
      end else begin
        seg_d = {seg_q[MAX_LEN-2:0], nxt};
        if (nxt == cherry)
          hold_d = HW'(EAT_HOLD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      seg_q     <= {MAX_LEN{START_C}};
      tick_q    <= '0;
      hold_q    <= '0;
      bump_q    <= 1'b0;
      is_body_q <= 1'b0;
      is_head_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      bump_q    <= bump_d;
      is_body_q <= is_body_d;
      is_head_q <= is_head_d;
    end
  end

  assign snakeEatCherry = (hold_q != '0);
  assign bump           = bump_q;
  assign headX          = seg_q[0].x;
  assign headY          = seg_q[0].y;
  assign isBody         = is_body_q;
  assign isHead         = is_head_q;

endmodule
